// File: rtl/dram_sw_bist.sv
// Distributed-RAM test block: switch-driven manual port plus a
// three-pass march self-test with fault injection and error reporting.
module dram_sw_bist #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 0,
    parameter int ERR_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  manual_we,
    input  logic [ADDR_WIDTH-1:0] manual_addr,
    input  logic [DATA_WIDTH-1:0] manual_wdata,
    input  logic                  start,
    input  logic                  inject,
    input  logic [ADDR_WIDTH-1:0] inject_addr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    localparam int D = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_W0, S_R0, S_R1, S_DRAIN, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] bist_addr_q, bist_addr_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic [ADDR_WIDTH-1:0] fail_q, fail_d;
    logic                  inj_q, inj_d;
    logic [ADDR_WIDTH-1:0] inj_addr_q, inj_addr_d;

    logic [DATA_WIDTH-1:0] mem [D];

    logic                  accept;
    logic                  last;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_now;
    logic                  cmp_en;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic                  chk_valid;
    logic [DATA_WIDTH-1:0] chk_data;
    logic [DATA_WIDTH-1:0] chk_exp;
    logic [ADDR_WIDTH-1:0] chk_addr;

    // Address bits repeated from the LSB upward across the word.
    function automatic logic [DATA_WIDTH-1:0] pat(
        input logic [ADDR_WIDTH-1:0] a
    );
        logic [DATA_WIDTH-1:0] p;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            p[i] = a[i % ADDR_WIDTH];
        end
        return p;
    endfunction

    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last   = &bist_addr_q;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_W0;
            S_W0:           if (last)  state_d = S_R0;
            S_R0:           if (last)  state_d = S_R1;
            S_R1: begin
                if (last) state_d = (READ_LATENCY == 1) ? S_DRAIN : S_DONE;
            end
            S_DRAIN:        state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    // FSM outputs: memory port control and compare expectation
    always_comb begin
        busy      = 1'b0;
        mem_we    = manual_we;
        mem_wdata = manual_wdata;
        cmp_en    = 1'b0;
        cmp_exp   = '0;
        unique case (state_q)
            S_W0: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = pat(bist_addr_q);
                if (inj_q && bist_addr_q == inj_addr_q) begin
                    mem_wdata[0] = ~mem_wdata[0];
                end
            end
            S_R0: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = ~pat(bist_addr_q);
                cmp_en    = 1'b1;
                cmp_exp   = pat(bist_addr_q);
            end
            S_R1: begin
                busy    = 1'b1;
                mem_we  = 1'b0;
                cmp_en  = 1'b1;
                cmp_exp = ~pat(bist_addr_q);
            end
            S_DRAIN: begin
                busy   = 1'b1;
                mem_we = 1'b0;
            end
            default: ;
        endcase
    end

    assign addr      = busy ? bist_addr_q : manual_addr;
    assign rd_now    = mem[addr];
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;
    assign fail_addr = fail_q;

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= mem_wdata;
    end

    generate
        if (READ_LATENCY == 1) begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                  chk_v_q, chk_v_d;
            logic [DATA_WIDTH-1:0] exp_q, exp_d;
            logic [ADDR_WIDTH-1:0] caddr_q, caddr_d;

            always_comb begin
                rdata_d = rd_now;
                chk_v_d = cmp_en;
                exp_d   = cmp_exp;
                caddr_d = bist_addr_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                    chk_v_q <= 1'b0;
                    exp_q   <= '0;
                    caddr_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                    chk_v_q <= chk_v_d;
                    exp_q   <= exp_d;
                    caddr_q <= caddr_d;
                end
            end

            assign rdata     = rdata_q;
            assign chk_valid = chk_v_q;
            assign chk_data  = rdata_q;
            assign chk_exp   = exp_q;
            assign chk_addr  = caddr_q;
        end else begin : g_comb
            assign rdata     = rd_now;
            assign chk_valid = cmp_en;
            assign chk_data  = rd_now;
            assign chk_exp   = cmp_exp;
            assign chk_addr  = bist_addr_q;
        end
    endgenerate

    always_comb begin
        bist_addr_d = bist_addr_q;
        err_d       = err_q;
        fail_d      = fail_q;
        inj_d       = inj_q;
        inj_addr_d  = inj_addr_q;
        if (accept) begin
            bist_addr_d = '0;
            err_d       = '0;
            fail_d      = '0;
            inj_d       = inject;
            inj_addr_d  = inject_addr;
        end else begin
            if (state_q == S_W0 || state_q == S_R0 || state_q == S_R1) begin
                bist_addr_d = bist_addr_q + ADDR_WIDTH'(1);
            end
            // err_q is still zero exactly on the first mismatch of a run
            if (chk_valid && chk_data != chk_exp) begin
                if (err_q != '1) err_d = err_q + ERR_WIDTH'(1);
                if (err_q == '0) fail_d = chk_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bist_addr_q <= '0;
            err_q       <= '0;
            fail_q      <= '0;
            inj_q       <= 1'b0;
            inj_addr_q  <= '0;
        end else begin
            bist_addr_q <= bist_addr_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
            inj_q       <= inj_d;
            inj_addr_q  <= inj_addr_d;
        end
    end

endmodule

// File: doc/dram_sw_bist.md
# dram_sw_bist

Parametrised distributed-RAM test block. It wraps a 2^ADDR_WIDTH x DATA_WIDTH LUT-RAM array with two access paths:
- a manual write/read port driven from board switches;
- a built-in three-pass march self-test (BIST) that reports error count, first failing address and pass/fail.

It sits under the board-level top, between the switch/LED glue and the UART reporter. It generalises the fixed 64x8 switch-driven DRAM test to arbitrary depth and width, selectable read latency and fault injection.

## Interface
- ADDR_WIDTH, 6, address bits; depth D = 2^ADDR_WIDTH
- DATA_WIDTH, 8, word width
- READ_LATENCY, 0, 0 = asynchronous LUT-RAM read; 1 = registered read
- ERR_WIDTH, 8, error counter width (saturating)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- manual_we  in  1  manual write strobe (honoured only when not busy)
- manual_addr  in  ADDR_WIDTH  manual address
- manual_wdata  in  DATA_WIDTH  manual write data
- start  in  1  BIST start request (one-cycle pulse or level; edge not required)
- inject  in  1  fault-injection enable, sampled at start
- inject_addr  in  ADDR_WIDTH  fault address, sampled at start
- rdata  out  DATA_WIDTH  read data at current address
- busy  out  1  BIST running
- done  out  1  BIST finished; held until next accepted start or reset
- pass  out  1  done && err_count == 0
- err_count  out  ERR_WIDTH  mismatches, saturates at all-ones
- fail_addr  out  ADDR_WIDTH  address of first mismatch

## Operation
- Memory contents are not reset. rst clears the FSM, counters and output registers only.
- Address mux: addr = busy ? bist_addr : manual_addr. rdata = mem[addr], either combinational or one cycle later per READ_LATENCY.
- Manual write: mem[manual_addr] <= manual_wdata when manual_we && !busy. manual_we is ignored while busy.
- Pattern: P(a) = a replicated from the LSB upward, truncated to DATA_WIDTH. For 6/8, P(5) = 0x45.
- FSM states: IDLE, W0, R0, R1, DRAIN, DONE.
  - IDLE/DONE + start → W0. On entry: bist_addr = 0, err_count = 0, fail_addr = 0, done = 0; inject and inject_addr are latched.
  - W0: write P(a). If inject is latched and a == inject_addr, write P(a)^1 (bit 0 flipped). Advance a; after a = D-1 go to R0.
  - R0: read a and compare with P(a). In the same cycle write ~P(a) to a; the read returns the pre-write value. After D-1 go to R1.
  - R1: read a and compare with ~P(a). After D-1 go to DRAIN if READ_LATENCY = 1, else DONE.
  - DRAIN: one cycle so the final registered compare completes; then DONE.
- Compare path: with READ_LATENCY = 1, the expected value and address are pipelined one stage alongside rdata.
- On each mismatch:
  - err_count increments unless it is at all-ones.
  - fail_addr loads the address only on the first mismatch of a run.
- start while busy is ignored. start in DONE restarts the test.
- Address counter: ADDR_WIDTH bits, wraps D-1 → 0 at each pass boundary.

## Timing
- Reset values: busy = 0, done = 0, pass = 0, err_count = 0, fail_addr = 0. rdata = 0 when READ_LATENCY = 1; when READ_LATENCY = 0 rdata is combinational from memory.
- busy rises the cycle after start is sampled in IDLE/DONE.
- busy is high for exactly 3D + READ_LATENCY cycles.
- done and pass rise in the same cycle busy falls.
- Manual read latency is READ_LATENCY cycles. Manual write followed by a read of the same address in the next cycle returns the new data.
- rst asserted mid-BIST: the FSM returns to IDLE immediately and all outputs take their reset values. Memory holds partial BIST data. A subsequent start runs a full, correct test.
- Simultaneous events:
  - start and manual_we in the same IDLE cycle: the manual write is performed, then the BIST begins.
  - start and rst together: rst wins.

## Test plan
- Clean run (6/8/0): start pulse, inject = 0 → busy high 192 cycles; then done = 1, pass = 1, err_count = 0, fail_addr = 0.
- Fault injection: inject = 1, inject_addr = 5 → err_count = 1 (R0 only), fail_addr = 5, pass = 0. A follow-up run with inject = 0 → pass = 1.
- Manual path, idle: write 0xA5 to address 17, then 0x3C to address 63 → reading 17 returns 0xA5 and reading 63 returns 0x3C at the specified latency. A manual_we pulse while busy leaves the memory pattern intact, so the run still passes.
- Restart and ignore:
  - start repeated at cycle 50 of a run → ignored, busy length unchanged.
  - start in DONE → new run begins; err_count cleared, done drops.
- Reset mid-run: rst at cycle 100 → all outputs return to reset values the same cycle. A new start then gives pass = 1 after 192 cycles.
- Parameter sweep (READ_LATENCY = 1, ADDR_WIDTH = 4, DATA_WIDTH = 16, ERR_WIDTH = 1):
  - clean run → busy high 49 cycles, pass = 1.
  - inject at address 15 → err_count = 1, fail_addr = 15.
